// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-path constants and the line buffer entry type.
// The Sysbus beat constants are shared with the fetch stage that assembles the lines.
package fetch_pkg;

    localparam int unsigned FB_LINE_WIDTH     = 512;
    localparam int unsigned FB_INSTR_WIDTH    = 32;
    localparam int unsigned FB_ADDR_WIDTH     = 64;

    localparam int unsigned LINE_BYTES        = 64;
    localparam int unsigned WORDS_PER_LINE    = 16;
    localparam int unsigned IDX_W             = 4;

    localparam int unsigned SYSBUS_BEATS      = 8;
    localparam int unsigned SYSBUS_BEAT_WIDTH = FB_LINE_WIDTH / SYSBUS_BEATS;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic [FB_LINE_WIDTH-1:0] data;
        logic [FB_ADDR_WIDTH-1:0] base;
        idx_t                     start;
        logic                     valid;
    } line_entry_t;

    function automatic logic [FB_ADDR_WIDTH-1:0] line_base(input logic [FB_ADDR_WIDTH-1:0] addr);
        return addr & ~FB_ADDR_WIDTH'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Line-in / instruction-out handshake bundle of the fetch buffer.
// master = fetch stage + decoder side, slave = the buffer itself.
interface fetch_buffer_if #(
    parameter int unsigned LINE_WIDTH  = 512,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 64
);
    logic                   line_valid;
    logic [LINE_WIDTH-1:0]  line_data;
    logic [ADDR_WIDTH-1:0]  line_addr;
    logic                   line_ready;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_ready;
    logic                   flush;
    logic                   halt;

    modport master (
        output line_valid, line_data, line_addr, instr_ready, flush,
        input  line_ready, instr_valid, instr, instr_pc, halt
    );

    modport slave (
        input  line_valid, line_data, line_addr, instr_ready, flush,
        output line_ready, instr_valid, instr, instr_pc, halt
    );
endinterface

// File: rtl/fetch_buffer_word_select.sv
// Combinational 16:1 head-word mux; also forms the PC of the selected word.
module word_select
    import fetch_pkg::*;
(
    input  logic [FB_LINE_WIDTH-1:0]  line_data,
    input  logic [FB_ADDR_WIDTH-1:0]  line_base,
    input  idx_t                      idx,
    output logic [FB_INSTR_WIDTH-1:0] word,
    output logic [FB_ADDR_WIDTH-1:0]  pc
);

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
            if (idx == IDX_W'(i)) begin
                word = line_data[i*FB_INSTR_WIDTH +: FB_INSTR_WIDTH];
            end
        end
        pc = line_base + FB_ADDR_WIDTH'({idx, 2'b00});
    end

endmodule

// File: rtl/fetch_buffer.sv
// Two-entry instruction line buffer: takes whole cache lines from the fetch stage and
// hands the decoder one instruction per cycle, with halt detection and redirect flush.
module fetch_buffer #(
    parameter int unsigned LINE_WIDTH  = 512,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 64
) (
    input  logic          clk,
    input  logic          reset,
    fetch_buffer_if.slave bus
);
    import fetch_pkg::*;

    line_entry_t            entries [2];
    line_entry_t            new_entry;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    idx_t                   idx;
    logic                   halted;

    logic [INSTR_WIDTH-1:0] head_word;
    logic [ADDR_WIDTH-1:0]  head_pc;
    logic                   head_present;
    logic                   head_zero;
    logic                   can_accept;
    logic                   emit;
    logic                   push;
    logic                   pop;
    logic                   retire;

    word_select u_word_select (
        .line_data (entries[rd_ptr].data),
        .line_base (entries[rd_ptr].base),
        .idx       (idx),
        .word      (head_word),
        .pc        (head_pc)
    );

    // The head entry's valid bit tracks count>0, so it doubles as the "buffer non-empty" flag.
    always_comb begin
        head_present = entries[rd_ptr].valid;
        head_zero    = head_present && (head_word == '0);
        can_accept   = (count < 2'd2) && !halted && !bus.flush;
        emit         = head_present && !head_zero && !halted;
        push         = bus.line_valid && can_accept && !reset;
        pop          = emit && bus.instr_ready && !bus.flush;
        retire       = pop && (idx == IDX_W'(WORDS_PER_LINE - 1));

        new_entry       = '0;
        new_entry.data  = bus.line_data;
        new_entry.base  = line_base(bus.line_addr);
        new_entry.start = bus.line_addr[IDX_W+1:2];
        new_entry.valid = 1'b1;
    end

    // Reset forces every output low for the reset cycle itself, independent of stale state.
    always_comb begin
        bus.line_ready  = can_accept && !reset;
        bus.instr_valid = emit && !reset;
        bus.instr       = (reset || !head_present) ? '0 : head_word;
        bus.instr_pc    = (reset || !head_present) ? '0 : head_pc;
        bus.halt        = halted && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            idx    <= '0;
            halted <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (head_zero) begin
                halted <= 1'b1;
            end

            if (bus.flush) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
                idx    <= '0;
                for (int unsigned i = 0; i < 2; i++) begin
                    entries[i].valid <= 1'b0;
                end
            end else begin
                if (push) begin
                    entries[wr_ptr] <= new_entry;
                    wr_ptr          <= ~wr_ptr;
                end
                if (retire) begin
                    entries[rd_ptr].valid <= 1'b0;
                    rd_ptr                <= ~rd_ptr;
                end
                count <= count + 2'(push) - 2'(retire);

                // Retire with count==1 and a concurrent push makes the incoming line the head.
                if (retire) begin
                    if (count == 2'd2) begin
                        idx <= entries[~rd_ptr].start;
                    end else if (push) begin
                        idx <= new_entry.start;
                    end else begin
                        idx <= '0;
                    end
                end else if (pop) begin
                    idx <= idx + 1'b1;
                end else if (push && (count == 2'd0)) begin
                    idx <= new_entry.start;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed table, corner-case sequences and
// random traffic, all compared against a queue-of-lines reference model.
module tb_fetch_buffer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_buffer_if #(.LINE_WIDTH(512), .INSTR_WIDTH(32), .ADDR_WIDTH(64)) bus ();

    fetch_buffer #(.LINE_WIDTH(512), .INSTR_WIDTH(32), .ADDR_WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [511:0] data;
        logic [63:0]  base;
        int unsigned  start;
    } mline_t;

    typedef struct {
        bit          lv;
        logic [63:0] addr;
        bit          rdy;
        bit          exp_lr;
        bit          exp_iv;
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    mline_t      q[$];
    int unsigned hidx;
    bit          mhalt;
    int          total = 0;
    int          bad   = 0;

    bit          e_ready;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;

    vec_t        tbl[$];

    function automatic logic [31:0] word_of(logic [511:0] d, int unsigned i);
        return d[32*i +: 32];
    endfunction

    function automatic logic [511:0] seq_line(logic [31:0] first, int zero_at);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = (i == zero_at) ? 32'h0 : first + 32'(i);
        return d;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] d;
        int           z;
        for (int i = 0; i < 16; i++) begin
            d[32*i +: 32] = $urandom;
            if (d[32*i +: 32] == 32'h0) d[32*i +: 32] = 32'h1;
        end
        if ($urandom % 12 == 0) begin
            z = $urandom_range(15, 0);
            d[32*z +: 32] = 32'h0;
        end
        return d;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit lv, logic [63:0] addr, logic [511:0] data, bit rdy, bit fl);
        bus.line_valid  = lv;
        bus.line_addr   = addr;
        bus.line_data   = data;
        bus.instr_ready = rdy;
        bus.flush       = fl;
    endtask

    function automatic void predict();
        logic [31:0] w;
        if (reset) begin
            e_ready = 0; e_valid = 0; e_instr = '0; e_pc = '0;
            return;
        end
        w       = (q.size() > 0) ? word_of(q[0].data, hidx) : 32'h0;
        e_ready = (q.size() < 2) && !mhalt && !bus.flush;
        e_valid = (q.size() > 0) && (w != 32'h0) && !mhalt;
        e_instr = w;
        e_pc    = (q.size() > 0) ? q[0].base + 64'(4 * hidx) : 64'h0;
    endfunction

    // Checks the current cycle against the model, then advances the model across the edge.
    task automatic tick();
        bit     push, pop, retire, was_empty;
        mline_t nl;
        #1;
        predict();
        check("line_ready", bus.line_ready, e_ready);
        check("instr_valid", bus.instr_valid, e_valid);
        if (reset) begin
            check("reset_instr", bus.instr, 0);
            check("reset_pc", bus.instr_pc, 0);
            check("reset_halt", bus.halt, 0);
        end else begin
            check("halt", bus.halt, mhalt);
            if (e_valid) begin
                check("instr", bus.instr, e_instr);
                check("instr_pc", bus.instr_pc, e_pc);
            end
        end
        @(posedge clk);
        if (reset) begin
            q.delete(); hidx = 0; mhalt = 0;
        end else begin
            push = bus.line_valid && e_ready;
            pop  = e_valid && bus.instr_ready;
            if (q.size() > 0 && word_of(q[0].data, hidx) == 32'h0) mhalt = 1;
            if (bus.flush) begin
                q.delete(); hidx = 0;
            end else begin
                was_empty = (q.size() == 0);
                retire    = pop && (hidx == 15);
                if (retire) void'(q.pop_front());
                else if (pop) hidx++;
                if (push) begin
                    nl.data  = bus.line_data;
                    nl.base  = bus.line_addr & ~64'h3f;
                    nl.start = bus.line_addr[5:2];
                    q.push_back(nl);
                end
                if ((retire || was_empty) && q.size() > 0) hidx = q[0].start;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_pops;
        bit          stalled;
        logic [31:0] prev_instr;
        logic [63:0] prev_pc;
        bit          bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        hidx = 0; mhalt = 0;
        drive(0, '0, '0, 0, 0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Directed table: aligned fill at 0x1000, then unaligned entry at 0x2028.
        tbl.push_back('{1'b1, 64'h1000, 1'b1, 1'b1, 1'b0, 64'h0, 32'h0});
        for (int k = 0; k < 16; k++)
            tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h1000 + 64'(4*k), 32'h13 + 32'(k)});
        tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 32'h0});
        tbl.push_back('{1'b1, 64'h2028, 1'b1, 1'b1, 1'b0, 64'h0, 32'h0});
        for (int k = 10; k < 16; k++)
            tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h2000 + 64'(4*k), 32'h13 + 32'(k)});
        tbl.push_back('{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0, 32'h0});

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].lv, tbl[k].addr, seq_line(32'h13, -1), tbl[k].rdy, 1'b0);
            #1;
            check("tbl_line_ready", bus.line_ready, tbl[k].exp_lr);
            check("tbl_instr_valid", bus.instr_valid, tbl[k].exp_iv);
            if (tbl[k].exp_iv) begin
                check("tbl_pc", bus.instr_pc, tbl[k].exp_pc);
                check("tbl_instr", bus.instr, tbl[k].exp_instr);
            end
            tick();
        end

        // Back-to-back lines fill the buffer, then drain without a bubble at 0x3040.
        drive(1, 64'h3000, seq_line(32'h300, -1), 0, 0); tick();
        drive(1, 64'h3040, seq_line(32'h400, -1), 0, 0); tick();
        drive(0, '0, '0, 0, 0);
        #1;
        check("full_line_ready", bus.line_ready, 0);
        tick();
        drive(0, '0, '0, 1, 0);
        for (int k = 0; k < 32; k++) begin
            #1;
            check("b2b_valid", bus.instr_valid, 1);
            check("b2b_pc", bus.instr_pc, 64'h3000 + 64'(4*k));
            tick();
        end
        tick();

        // Backpressure: ready pattern 1,0,0,1 keeps stalled outputs stable.
        drive(1, 64'h5000, seq_line(32'h500, -1), 0, 0); tick();
        n_pops = 0; stalled = 0; prev_instr = '0; prev_pc = '0;
        for (int c = 0; c < 40; c++) begin
            drive(0, '0, '0, bp_pat[c % 4], 0);
            #1;
            if (stalled) begin
                check("bp_hold_instr", bus.instr, prev_instr);
                check("bp_hold_pc", bus.instr_pc, prev_pc);
            end
            stalled    = bus.instr_valid && !bus.instr_ready;
            prev_instr = bus.instr;
            prev_pc    = bus.instr_pc;
            if (bus.instr_valid && bus.instr_ready) n_pops++;
            tick();
        end
        check("bp_pop_count", 64'(n_pops), 16);

        // Halt on a zero word at index 3 of a line at 0x4000.
        drive(1, 64'h4000, seq_line(32'h600, 3), 1, 0); tick();
        drive(0, '0, '0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("halt_pc", bus.instr_pc, 64'h4000 + 64'(4*k));
            tick();
        end
        tick();
        drive(1, 64'h4100, seq_line(32'h700, -1), 1, 0);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("halt_sticky", bus.halt, 1);
            check("halt_no_ready", bus.line_ready, 0);
            check("halt_no_valid", bus.instr_valid, 0);
            tick();
        end
        reset = 1'b1; tick(); reset = 1'b0;
        drive(0, '0, '0, 0, 0);
        #1;
        check("post_halt_reset_ready", bus.line_ready, 1);
        check("post_halt_reset_halt", bus.halt, 0);
        tick();

        // Flush after 5 pops with a line offered in the flush cycle.
        drive(1, 64'h6000, seq_line(32'h800, -1), 1, 0); tick();
        drive(0, '0, '0, 1, 0);
        for (int k = 0; k < 5; k++) tick();
        drive(1, 64'h7000, seq_line(32'h900, -1), 1, 1);
        #1;
        check("flush_line_ready", bus.line_ready, 0);
        tick();
        drive(0, '0, '0, 1, 0);
        #1;
        check("flush_empty_valid", bus.instr_valid, 0);
        check("flush_ready_after", bus.line_ready, 1);
        tick();

        // Reset in the middle of a line.
        drive(1, 64'h8010, seq_line(32'ha00, -1), 1, 0); tick();
        drive(0, '0, '0, 1, 0); tick(); tick(); tick();
        drive(1, 64'h9000, seq_line(32'hb00, -1), 1, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        drive(0, '0, '0, 1, 0);
        #1;
        check("midreset_ready", bus.line_ready, 1);
        check("midreset_valid", bus.instr_valid, 0);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom % 2 == 0, {$urandom, $urandom}, rand_line(),
                  $urandom % 4 != 0, $urandom % 30 == 0);
            reset = ($urandom % 200 == 0) || (mhalt && $urandom % 6 == 0);
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
